// File: rtl/tsu_ts_queue.sv
// Timestamp record FIFO between the PTP timestamp unit and the register block.
// Optional messageType accept filter is enabled by defining TSU_Q_FILTER_EN.
module tsu_ts_queue #(
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ts_valid,
    input  logic [127:0] ts_data,
    input  logic [79:0]  ts_time,
    input  logic         q_rst,
    input  logic         q_rd_en,
`ifdef TSU_Q_FILTER_EN
    input  logic [7:0]   ptp_msgid_mask,
`endif
    output logic [7:0]   q_stat,
    output logic [127:0] q_data,
    output logic [79:0]  q_ts
);

    localparam int            DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LVL_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [207:0]      r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_ovf;
    logic [127:0]      r_q_data;
    logic [79:0]       r_q_ts;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_set;
    logic [207:0]      w_rd_entry;
    logic [5:0]        w_level6;

`ifdef TSU_Q_FILTER_EN
    assign w_accept = ptp_msgid_mask[ts_data[122:120]];
`else
    assign w_accept = 1'b1;
`endif

    assign w_full     = (r_level == LVL_FULL);
    assign w_empty    = (r_level == '0);
    assign w_pop      = q_rd_en && !w_empty && !q_rst;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_push     = ts_valid && w_accept && !q_rst && (!w_full || w_pop);
    assign w_ovf_set  = ts_valid && w_accept && !q_rst && w_full && !w_pop;
    assign w_rd_entry = r_mem[r_rd_ptr];
    assign w_level6   = 6'(r_level);

    // Storage is never reset; only written slots are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ts_data, ts_time};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_q_data <= '0;
            r_q_ts   <= '0;
        end else if (q_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_q_data <= '0;
            r_q_ts   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_q_data <= w_rd_entry[207:80];
                r_q_ts   <= w_rd_entry[79:0];
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign q_stat = {r_ovf, w_full, w_level6};
    assign q_data = r_q_data;
    assign q_ts   = r_q_ts;

endmodule

// File: tb/tb_tsu_ts_queue.sv
// Directed self-checking bench for tsu_ts_queue (ADDR_W=4, depth 16).
module tb_tsu_ts_queue;

    logic         clk;
    logic         rst_n;
    logic         ts_valid;
    logic [127:0] ts_data;
    logic [79:0]  ts_time;
    logic         q_rst;
    logic         q_rd_en;
`ifdef TSU_Q_FILTER_EN
    logic [7:0]   ptp_msgid_mask;
`endif
    logic [7:0]   q_stat;
    logic [127:0] q_data;
    logic [79:0]  q_ts;

    int n_cmp = 0;
    int n_err = 0;

    tsu_ts_queue #(.ADDR_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ts_valid       (ts_valid),
        .ts_data        (ts_data),
        .ts_time        (ts_time),
        .q_rst          (q_rst),
        .q_rd_en        (q_rd_en),
`ifdef TSU_Q_FILTER_EN
        .ptp_msgid_mask (ptp_msgid_mask),
`endif
        .q_stat         (q_stat),
        .q_data         (q_data),
        .q_ts           (q_ts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mk_data(input logic [79:0] t);
        return {48'hC0FF_EE12_3456, t ^ 80'h5A5A_0000_0000_0000_A5A5};
    endfunction

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Every stimulus task drives just after a rising edge and returns 1 time unit after the next one.
    task automatic push_rec(input logic [79:0] t);
        ts_valid = 1'b1;
        ts_time  = t;
        ts_data  = mk_data(t);
        @(posedge clk); #1;
        ts_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [79:0] t);
        q_rd_en = 1'b1;
        @(posedge clk); #1;
        q_rd_en = 1'b0;
        check_val({tag, "_ts"}, q_ts, t);
        check_val({tag, "_data"}, q_data, mk_data(t));
    endtask

    task automatic push_pop(input logic [79:0] t);
        ts_valid = 1'b1;
        ts_time  = t;
        ts_data  = mk_data(t);
        q_rd_en  = 1'b1;
        @(posedge clk); #1;
        ts_valid = 1'b0;
        q_rd_en  = 1'b0;
    endtask

    task automatic pulse_qrst(input logic with_push);
        q_rst    = 1'b1;
        ts_valid = with_push;
        ts_time  = 80'hDEAD;
        ts_data  = mk_data(80'hDEAD);
        @(posedge clk); #1;
        q_rst    = 1'b0;
        ts_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        ts_valid = 1'b0;
        ts_data  = '0;
        ts_time  = '0;
        q_rst    = 1'b0;
        q_rd_en  = 1'b0;
`ifdef TSU_Q_FILTER_EN
        ptp_msgid_mask = 8'hFF;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_stat", q_stat, 8'h00);
        check_val("reset_data", q_data, 128'h0);
        check_val("reset_ts", q_ts, 80'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic three-record ordering
        for (int i = 1; i <= 3; i++) push_rec(80'(i));
        check_val("three_stat", q_stat, 8'h03);
        for (int i = 1; i <= 3; i++) pop_chk($sformatf("three_pop%0d", i), 80'(i));
        check_val("three_empty", q_stat, 8'h00);

        // Overflow: 17 pushes into 16 slots
        for (int i = 1; i <= 17; i++) push_rec(80'(i));
        check_val("ovf_stat", q_stat, 8'hD0);
        for (int i = 1; i <= 16; i++) pop_chk($sformatf("ovf_pop%0d", i), 80'(i));
        check_val("ovf_drained", q_stat, 8'h80);
        pulse_qrst(1'b0);
        check_val("qrst_stat", q_stat, 8'h00);
        check_val("qrst_ts", q_ts, 80'h0);

        // Full queue, simultaneous push and pop
        for (int i = 0; i < 16; i++) push_rec(80'(100 + i));
        push_pop(80'd200);
        check_val("fullpp_ts", q_ts, 80'd100);
        check_val("fullpp_stat", q_stat, 8'h50);
        for (int i = 1; i < 16; i++) pop_chk($sformatf("fullpp_pop%0d", i), 80'(100 + i));
        pop_chk("fullpp_new", 80'd200);
        check_val("fullpp_empty", q_stat, 8'h00);

        // Pointer wrap: push 10, pop 10, twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) push_rec(80'(300 + 10 * r + i));
            check_val($sformatf("wrap%0d_stat", r), q_stat, 8'h0A);
            for (int i = 0; i < 10; i++) pop_chk($sformatf("wrap%0d_pop%0d", r, i), 80'(300 + 10 * r + i));
        end
        q_rd_en = 1'b1;
        @(posedge clk); #1;
        q_rd_en = 1'b0;
        check_val("empty_pop_ts", q_ts, 80'd319);
        check_val("empty_pop_data", q_data, mk_data(80'd319));
        check_val("empty_pop_stat", q_stat, 8'h00);

        // Push+pop on empty, then on a partially filled queue
        push_pop(80'd500);
        check_val("emptypp_stat", q_stat, 8'h01);
        check_val("emptypp_ts", q_ts, 80'd319);
        push_rec(80'd501);
        push_pop(80'd502);
        check_val("midpp_ts", q_ts, 80'd500);
        check_val("midpp_stat", q_stat, 8'h02);
        pop_chk("midpp_pop1", 80'd501);
        pop_chk("midpp_pop2", 80'd502);

        // level 5 with ovf, then q_rst with a concurrent push
        for (int i = 0; i < 17; i++) push_rec(80'(600 + i));
        for (int i = 0; i < 11; i++) pop_chk($sformatf("l5_pop%0d", i), 80'(600 + i));
        check_val("l5_stat", q_stat, 8'h85);
        pulse_qrst(1'b1);
        check_val("l5_qrst_stat", q_stat, 8'h00);
        check_val("l5_qrst_data", q_data, 128'h0);
        check_val("l5_qrst_ts", q_ts, 80'h0);
        q_rd_en = 1'b1;
        @(posedge clk); #1;
        q_rd_en = 1'b0;
        check_val("l5_not_stored_stat", q_stat, 8'h00);
        check_val("l5_not_stored_ts", q_ts, 80'h0);

        // Asynchronous reset during a push
        push_rec(80'd700);
        push_rec(80'd701);
        check_val("arst_pre_stat", q_stat, 8'h02);
        ts_valid = 1'b1;
        ts_time  = 80'd702;
        ts_data  = mk_data(80'd702);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_async_stat", q_stat, 8'h00);
        @(posedge clk); #1;
        ts_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        check_val("arst_post_stat", q_stat, 8'h00);
        push_rec(80'd710);
        pop_chk("arst_after_pop", 80'd710);

`ifdef TSU_Q_FILTER_EN
        // Filter: only messageType 0 accepted
        ptp_msgid_mask = 8'h01;
        ts_valid = 1'b1;
        ts_time  = 80'd800;
        ts_data  = {4'h0, 4'h0, 120'h1234};
        @(posedge clk); #1;
        ts_time  = 80'd801;
        ts_data  = {4'h0, 4'h1, 120'h5678};
        @(posedge clk); #1;
        ts_valid = 1'b0;
        check_val("filt_stat", q_stat, 8'h01);
        q_rd_en = 1'b1;
        @(posedge clk); #1;
        q_rd_en = 1'b0;
        check_val("filt_ts", q_ts, 80'd800);
        check_val("filt_data", q_data, {4'h0, 4'h0, 120'h1234});
        check_val("filt_empty", q_stat, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
